fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_ifid_register.sv | 34 +++
 rtl/fetch_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM state type and constants for the instruction fetch stage.
package fetch_unit_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: pipeline control in, instruction memory port, IF/ID outputs.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic [ILEN-1:0] imem_rdata;
   logic [XLEN-1:0] imem_addr;
   logic            ifid_valid;
   logic [ILEN-1:0] ifid_instr;
   logic [XLEN-1:0] ifid_pc;
   logic [XLEN-1:0] ifid_pc_plus4;
   logic            misaligned_err;
   logic [31:0]     fetch_count;

   modport master (
      input  stall, redirect_valid, redirect_target, imem_rdata,
      output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
             misaligned_err, fetch_count
   );

   modport slave (
      output stall, redirect_valid, redirect_target, imem_rdata,
      input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4,
             misaligned_err, fetch_count
   );
endinterface

// File: rtl/fetch_unit_ifid_register.sv
// IF/ID pipeline register: load captures a new instruction, flush only drops valid.
module ifid_register
   import fetch_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            flush,
   input  logic [ILEN-1:0] instr_d,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] pc_plus4_d,
   output logic            valid,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         instr    <= '0;
         pc       <= '0;
         pc_plus4 <= '0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= instr_d;
         pc       <= pc_d;
         pc_plus4 <= pc_plus4_d;
      end else if (flush) begin
         valid    <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT sequencing and IF/ID capture.
//  state  | meaning
//  S_IDLE | one cycle after reset, PC held, nothing captured
//  S_RUN  | fetching; stall holds, redirect flushes and retargets
//  S_HALT | misaligned redirect seen; frozen until reset
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_unit_if.master bus
);

   fetch_state_t    state, state_nx;
   logic [XLEN-1:0] pc, pc_nx, pc_plus4, eff_target;
   logic [31:0]     fetch_count;
   logic            misaligned_err;
   logic            ifid_load, ifid_flush, cnt_inc, err_set;

   assign pc_plus4      = pc + 64'd4;
   assign eff_target    = bus.redirect_target & ~64'd1;
   assign bus.imem_addr = {2'b00, pc[XLEN-1:2]};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  state_nx = S_RUN;
         S_RUN:   if (bus.redirect_valid && eff_target[1]) state_nx = S_HALT;
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

   // Redirect is checked before stall so a taken branch always wins.
   always_comb begin
      pc_nx      = pc;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      cnt_inc    = 1'b0;
      err_set    = 1'b0;
      if (state == S_RUN) begin
         if (bus.redirect_valid) begin
            ifid_flush = 1'b1;
            if (eff_target[1]) err_set = 1'b1;
            else               pc_nx   = eff_target;
         end else if (!bus.stall) begin
            ifid_load = 1'b1;
            cnt_inc   = 1'b1;
            pc_nx     = pc_plus4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc             <= RESET_PC;
         fetch_count    <= '0;
         misaligned_err <= 1'b0;
      end else begin
         pc <= pc_nx;
         if (cnt_inc) fetch_count    <= fetch_count + 32'd1;
         if (err_set) misaligned_err <= 1'b1;
      end
   end

   assign bus.fetch_count    = fetch_count;
   assign bus.misaligned_err = misaligned_err;

   ifid_register u_ifid (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ifid_load),
      .flush      (ifid_flush),
      .instr_d    (bus.imem_rdata),
      .pc_d       (pc),
      .pc_plus4_d (pc_plus4),
      .valid      (bus.ifid_valid),
      .instr      (bus.ifid_instr),
      .pc         (bus.ifid_pc),
      .pc_plus4   (bus.ifid_pc_plus4)
   );

endmodule
